// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding, bus widths
// and the latched request record.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_byte_array.sv
// DEPTH x 32-bit storage built from four byte lanes; one access strobe does a
// byte-masked write and a read-first registered read of the same word.
module mem_byte_array #(
  parameter int DEPTH = 1024,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic             wen_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wmask_i,
  output logic [31:0]      rdata_o
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (en_i) begin
          if (wen_i && wmask_i[gi]) begin
            lane_mem[idx_i] <= wdata_i[8*gi +: 8];
          end
          rd_q <= lane_mem[idx_i];
        end
      end

      assign rdata_o[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed access latency.
module mem_responder
  import mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      LAT_INIT  = 4'(LATENCY);
  localparam logic [ADDR_W:0] MEM_BYTES = {1'b0, 32'(DEPTH)} << 2;

  state_e            state_q;
  logic [3:0]        cnt_q;
  mem_req_t          req_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic              rd_ok_q;

  logic              access_d;
  logic              in_range_d;
  logic [ADDR_W-1:0] offset_d;
  logic [DATA_W-1:0] mem_rdata;

  always_comb begin
    offset_d = req_q.addr - BASE_ADDR;
    access_d = (state_q == WAIT) && (cnt_q == 4'd0);
    // Lower bound checked separately so the subtraction cannot wrap into range.
    in_range_d = (req_q.addr >= BASE_ADDR) && ({1'b0, offset_d} < MEM_BYTES);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      req_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_q       <= '{wen: req_wen, addr: req_addr, wdata: req_wdata, wmask: req_wmask};
            cnt_q       <= LAT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= !in_range_d;
            rd_ok_q      <= !req_q.wen && in_range_d;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_ok_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_bits;

  mem_byte_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .en_i    (access_d && in_range_d),
    .wen_i   (req_q.wen),
    .idx_i   (offset_d[IDX_W+1:2]),
    .wdata_i (req_q.wdata),
    .wmask_i (req_q.wmask),
    .rdata_o (mem_rdata)
  );

  assign unused_bits = ^{offset_d[1:0], offset_d[ADDR_W-1:IDX_W+2]};

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  // Array read register is not reset, so gate it to give 0 for writes, errors and idle.
  assign resp_rdata = rd_ok_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 runs LATENCY=2, instance 1 runs LATENCY=0.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        resp_ready[2];
  logic        req_ready [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  mem_responder #(.LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Present a request from a negedge and return at the negedge after acceptance.
  task automatic send(input int d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask, input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = mask;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) check("accept_timeout", {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) begin
      req_valid[d] = 1'b0;
      req_addr[d]  = ~addr;
      req_wdata[d] = ~wdata;
      req_wmask[d] = ~mask;
    end
  endtask

  // Count edges from acceptance to resp_valid, then complete the handshake.
  task automatic get_resp(input int d, output logic [31:0] rdata, output logic err, output int edges);
    edges = 0;
    while (!resp_valid[d] && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!resp_valid[d]) check("resp_timeout", {31'b0, resp_valid[d]}, 32'd1);
    rdata = resp_rdata[d];
    err   = resp_err[d];
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("resp_clear", {31'b0, resp_valid[d]}, 32'd0);
  endtask

  task automatic xact(input string tag, input int d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_edges);
    logic [31:0] rdata;
    logic        err;
    int          edges;
    send(d, wen, addr, wdata, mask, 1'b0);
    get_resp(d, rdata, err, edges);
    check({tag, ".rdata"}, rdata, exp_rdata);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".lat"}, 32'(edges), 32'(exp_edges));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          edges;
    logic        seen;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wmask[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset.req_ready", {31'b0, req_ready[d]}, 32'd1);
      check("reset.resp_valid", {31'b0, resp_valid[d]}, 32'd0);
      check("reset.resp_rdata", resp_rdata[d], 32'd0);
      check("reset.resp_err", {31'b0, resp_err[d]}, 32'd0);
    end
    reset = 1'b1;

    // LATENCY=2: response 3 edges after acceptance
    xact("wr_full",   0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 3);
    xact("rd_full",   0, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 3);
    xact("wr_byte0",  0, 1'b1, 32'h8000_0004, 32'h0000_00AA, 4'h1, 32'h0, 1'b0, 3);
    xact("rd_byte0",  0, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0, 3);
    xact("wr_nomask", 0, 1'b1, 32'h8000_0004, 32'h5555_5555, 4'h0, 32'h0, 1'b0, 3);
    xact("rd_nomask", 0, 1'b0, 32'h8000_0007, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0, 3);
    xact("wr_first",  0, 1'b1, 32'h8000_0000, 32'h0123_4567, 4'hF, 32'h0, 1'b0, 3);
    xact("wr_last",   0, 1'b1, 32'h8000_0FFC, 32'h89AB_CDEF, 4'hF, 32'h0, 1'b0, 3);
    xact("wr_w2",     0, 1'b1, 32'h8000_0008, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 3);
    xact("rd_below",  0, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1, 3);
    xact("rd_above",  0, 1'b0, 32'h8000_1000, 32'h0,         4'h0, 32'h0, 1'b1, 3);
    xact("wr_above",  0, 1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 3);
    xact("rd_first",  0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0123_4567, 1'b0, 3);
    xact("rd_last",   0, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h89AB_CDEF, 1'b0, 3);

    // Response backpressure with a request held pending
    send(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1);
    edges = 0;
    while (!resp_valid[0] && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("hold.lat", 32'(edges), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("hold.resp_valid", {31'b0, resp_valid[0]}, 32'd1);
      check("hold.resp_rdata", resp_rdata[0], 32'hDEAD_BEAA);
      check("hold.req_ready", {31'b0, req_ready[0]}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[0] = 1'b0;
    check("hs.resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("hs.resp_rdata", resp_rdata[0], 32'd0);
    check("hs.req_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("held.accepted", {31'b0, req_ready[0]}, 32'd0);
    req_valid[0] = 1'b0;
    get_resp(0, rdata, err, edges);
    check("held.rdata", rdata, 32'hDEAD_BEAA);
    check("held.lat", 32'(edges), 32'd3);

    // Reset during WAIT of a write: write dropped, no response
    send(0, 1'b1, 32'h8000_0008, 32'h2222_2222, 4'hF, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("abort.req_ready", {31'b0, req_ready[0]}, 32'd1);
    check("abort.resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    check("abort.resp_rdata", resp_rdata[0], 32'd0);
    check("abort.resp_err", {31'b0, resp_err[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[0]) seen = 1'b1;
    end
    check("abort.no_resp", {31'b0, seen}, 32'd0);
    xact("rd_after_abort", 0, 1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 3);

    // LATENCY=0: response one edge after acceptance
    xact("l0.wr_a",  1, 1'b1, 32'h8000_0010, 32'h0000_BEEF, 4'hF, 32'h0, 1'b0, 1);
    xact("l0.wr_b",  1, 1'b1, 32'h8000_0014, 32'h1234_0000, 4'hC, 32'h0, 1'b0, 1);
    xact("l0.wr_b2", 1, 1'b1, 32'h8000_0014, 32'h0000_5678, 4'h3, 32'h0, 1'b0, 1);
    xact("l0.rd_a",  1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h0000_BEEF, 1'b0, 1);
    xact("l0.rd_b",  1, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1);
    xact("l0.rd_oob", 1, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
